// File: rtl/sa_pkg.sv
// Shared constants, op encoding and clamp helpers for the systolic-array PE.
package sa_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;
    localparam int LIM_W      = 128;

    typedef enum logic [1:0] {HOLD, DRAIN, FIRST, MAC} pe_op_t;

    // Limits are returned in a wide container; callers keep the low w bits.
    function automatic logic [LIM_W-1:0] acc_max(input int w, input bit sgn);
        logic [LIM_W-1:0] one;
        one = {{(LIM_W-1){1'b0}}, 1'b1};
        return sgn ? (one << (w - 1)) - one : (one << w) - one;
    endfunction

    function automatic logic [LIM_W-1:0] acc_min(input int w, input bit sgn);
        logic [LIM_W-1:0] one;
        one = {{(LIM_W-1){1'b0}}, 1'b1};
        return sgn ? (one << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: extend, multiply, add at ACC_W+1 bits, saturate or wrap.
module pe_mac
    import sa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  next_acc,
    output logic              ovf
);

    localparam int PW  = 2 * DATA_W;
    localparam int PAD = ACC_W - PW;
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W, SIGNED != 0));

    logic [PW-1:0]    ax, bx, prod;
    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum;
    logic             sx_a, sx_b, sx_p;

    assign sx_a = (SIGNED != 0) & a[DATA_W-1];
    assign sx_b = (SIGNED != 0) & b[DATA_W-1];
    assign ax   = {{DATA_W{sx_a}}, a};
    assign bx   = {{DATA_W{sx_b}}, b};
    // Low PW bits of the product of extended operands are exact for both signednesses.
    assign prod = ax * bx;
    assign sx_p = (SIGNED != 0) & prod[PW-1];

    generate
        if (PAD > 0) begin : g_pad
            assign ext = {{PAD{sx_p}}, prod};
        end else begin : g_nopad
            assign ext = prod[ACC_W-1:0];
        end
    endgenerate

    assign sum = {1'b0, acc} + {1'b0, ext};

    always_comb begin
        ovf      = 1'b0;
        next_acc = sum[ACC_W-1:0];
        if (SIGNED != 0)
            ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        else
            ovf = sum[ACC_W];
        if (ovf && (SAT != 0)) begin
            if ((SIGNED != 0) && acc[ACC_W-1])
                next_acc = MIN_V;
            else
                next_acc = MAX_V;
        end
    end

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary PE: forwards A east / B south one cycle late and owns the accumulator,
// which can restart per tile or shift out through the C chain in drain mode.
module systolic_pe #(
    parameter int DATA_W = sa_pkg::DATA_W_DEF,
    parameter int ACC_W  = sa_pkg::ACC_W_DEF,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DATA_W-1:0] A_in,
    input  logic              A_vld_in,
    input  logic              A_first_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic              B_vld_in,
    output logic [DATA_W-1:0] A_out,
    output logic              A_vld_out,
    output logic              A_first_out,
    output logic [DATA_W-1:0] B_out,
    output logic              B_vld_out,
    input  logic              DRAIN,
    input  logic [ACC_W-1:0]  C_in,
    output logic [ACC_W-1:0]  C_out,
    output logic              OVF
);

    import sa_pkg::*;

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_width
            $error("systolic_pe: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    pe_op_t           op;
    logic [ACC_W-1:0] acc_src;
    logic [ACC_W-1:0] next_acc;
    logic             mac_ovf;

    always_comb begin
        op = HOLD;
        if (DRAIN)
            op = sa_pkg::DRAIN;
        else if (A_vld_in && B_vld_in)
            op = A_first_in ? FIRST : MAC;
    end

    // A tile restart adds the product to zero, so it shares the MAC datapath.
    assign acc_src = (op == FIRST) ? '0 : C_out;

    pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_mac (
        .a        (A_in),
        .b        (B_in),
        .acc      (acc_src),
        .next_acc (next_acc),
        .ovf      (mac_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            A_out       <= '0;
            A_vld_out   <= 1'b0;
            A_first_out <= 1'b0;
            B_out       <= '0;
            B_vld_out   <= 1'b0;
            C_out       <= '0;
            OVF         <= 1'b0;
        end else if (EN) begin
            A_out       <= A_in;
            A_vld_out   <= A_vld_in;
            A_first_out <= A_first_in;
            B_out       <= B_in;
            B_vld_out   <= B_vld_in;
            case (op)
                sa_pkg::DRAIN: C_out <= C_in;
                FIRST: begin
                    C_out <= next_acc;
                    OVF   <= 1'b0;
                end
                MAC: begin
                    C_out <= next_acc;
                    if (mac_ovf)
                        OVF <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench: signed/saturating PE, unsigned/wrapping PE, and a 3-deep drain column.
module tb_systolic_pe;

    localparam int DW = 8;
    localparam int AW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // shared stimulus for the two standalone PEs
    logic          rst, en, av, af, bv, drain;
    logic [DW-1:0] a, b;
    logic [AW-1:0] cin;

    logic [DW-1:0] s_ao, s_bo, u_ao, u_bo;
    logic          s_avo, s_afo, s_bvo, s_ovf, u_avo, u_afo, u_bvo, u_ovf;
    logic [AW-1:0] s_c, u_c;

    // drain column stimulus
    logic          c_av, c_af, c_bv, c_drain;
    logic [DW-1:0] c_a0, c_a1, c_a2, c_b;
    logic [AW-1:0] c_head;

    logic [DW-1:0] h_ao, m_ao, t_ao, h_bo, m_bo, t_bo;
    logic          h_avo, m_avo, t_avo, h_afo, m_afo, t_afo;
    logic          h_bvo, m_bvo, t_bvo, h_ovf, m_ovf, t_ovf;
    logic [AW-1:0] h_c, m_c, t_c;

    systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SAT(1)) dut_s (
        .CLK(clk), .RST(rst), .EN(en),
        .A_in(a), .A_vld_in(av), .A_first_in(af), .B_in(b), .B_vld_in(bv),
        .A_out(s_ao), .A_vld_out(s_avo), .A_first_out(s_afo), .B_out(s_bo), .B_vld_out(s_bvo),
        .DRAIN(drain), .C_in(cin), .C_out(s_c), .OVF(s_ovf)
    );

    systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(0), .SAT(0)) dut_u (
        .CLK(clk), .RST(rst), .EN(en),
        .A_in(a), .A_vld_in(av), .A_first_in(af), .B_in(b), .B_vld_in(bv),
        .A_out(u_ao), .A_vld_out(u_avo), .A_first_out(u_afo), .B_out(u_bo), .B_vld_out(u_bvo),
        .DRAIN(drain), .C_in(cin), .C_out(u_c), .OVF(u_ovf)
    );

    systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SAT(1)) pe_head (
        .CLK(clk), .RST(rst), .EN(en),
        .A_in(c_a0), .A_vld_in(c_av), .A_first_in(c_af), .B_in(c_b), .B_vld_in(c_bv),
        .A_out(h_ao), .A_vld_out(h_avo), .A_first_out(h_afo), .B_out(h_bo), .B_vld_out(h_bvo),
        .DRAIN(c_drain), .C_in(c_head), .C_out(h_c), .OVF(h_ovf)
    );

    systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SAT(1)) pe_mid (
        .CLK(clk), .RST(rst), .EN(en),
        .A_in(c_a1), .A_vld_in(c_av), .A_first_in(c_af), .B_in(c_b), .B_vld_in(c_bv),
        .A_out(m_ao), .A_vld_out(m_avo), .A_first_out(m_afo), .B_out(m_bo), .B_vld_out(m_bvo),
        .DRAIN(c_drain), .C_in(h_c), .C_out(m_c), .OVF(m_ovf)
    );

    systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SAT(1)) pe_tail (
        .CLK(clk), .RST(rst), .EN(en),
        .A_in(c_a2), .A_vld_in(c_av), .A_first_in(c_af), .B_in(c_b), .B_vld_in(c_bv),
        .A_out(t_ao), .A_vld_out(t_avo), .A_first_out(t_afo), .B_out(t_bo), .B_vld_out(t_bvo),
        .DRAIN(c_drain), .C_in(m_c), .C_out(t_c), .OVF(t_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; av = 1'b0; af = 1'b0; bv = 1'b0; drain = 1'b0;
        a = '0; b = '0; cin = '0;
        c_av = 1'b0; c_af = 1'b0; c_bv = 1'b0; c_drain = 1'b0;
        c_a0 = '0; c_a1 = '0; c_a2 = '0; c_b = '0; c_head = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_c", 32'(s_c), 32'h0);
        check("rst_ovf", 32'(s_ovf), 32'h0);
        check("rst_aout", 32'(s_ao), 32'h0);
        check("rst_avld", 32'(s_avo), 32'h0);

        // forwarding latency and stall; the pair also MACs 0x12*0x34 = 936 from zero
        en = 1'b1; a = 8'h12; av = 1'b1; b = 8'h34; bv = 1'b1;
        step();
        en = 1'b0; a = 8'h55; av = 1'b0; b = 8'h66; bv = 1'b0;
        check("fwd_a", 32'(s_ao), 32'h12);
        check("fwd_avld", 32'(s_avo), 32'h1);
        check("fwd_b", 32'(s_bo), 32'h34);
        check("fwd_bvld", 32'(s_bvo), 32'h1);
        check("fwd_acc", 32'(s_c), 32'd936);
        step();
        step();
        check("stall_a", 32'(s_ao), 32'h12);
        check("stall_avld", 32'(s_avo), 32'h1);
        check("stall_b", 32'(s_bo), 32'h34);
        check("stall_acc", 32'(s_c), 32'd936);

        // signed FIRST then MAC: -3*7 = -21, then -21 + 20 = -1
        en = 1'b1; a = 8'hFD; b = 8'h07; av = 1'b1; bv = 1'b1; af = 1'b1;
        step();
        check("first_neg", 32'(s_c), 32'hFFFEB);
        af = 1'b0; a = 8'h05; b = 8'h04;
        step();
        check("mac_neg1", 32'(s_c), 32'hFFFFF);
        check("mac_ovf0", 32'(s_ovf), 32'h0);

        // positive saturation: 16384 per beat, limit 524287
        a = 8'h80; b = 8'h80; af = 1'b1;
        step();
        af = 1'b0;
        repeat (30) step();
        check("sat_31", 32'(s_c), 32'd507904);
        check("sat_31_ovf", 32'(s_ovf), 32'h0);
        step();
        check("sat_32", 32'(s_c), 32'h7FFFF);
        check("sat_32_ovf", 32'(s_ovf), 32'h1);
        step();
        check("sat_hold", 32'(s_c), 32'h7FFFF);
        a = 8'h01; b = 8'h01; af = 1'b1;
        step();
        check("restart_c", 32'(s_c), 32'h1);
        check("restart_ovf", 32'(s_ovf), 32'h0);
        check("restart_u", 32'(u_c), 32'h1);

        // unsigned wrap: preset via drain, then 0xFFFF0 + 0x20
        af = 1'b0; av = 1'b0; bv = 1'b0; drain = 1'b1; cin = 20'hFFFF0;
        step();
        check("preset_u", 32'(u_c), 32'hFFFF0);
        check("drain_ovf_hold", 32'(u_ovf), 32'h0);
        drain = 1'b0; a = 8'h10; b = 8'h02; av = 1'b1; bv = 1'b1;
        step();
        check("wrap_c", 32'(u_c), 32'h00010);
        check("wrap_ovf", 32'(u_ovf), 32'h1);
        check("signed_no_ovf_c", 32'(s_c), 32'h00010);
        check("signed_no_ovf", 32'(s_ovf), 32'h0);

        // negative saturation: (min+16) + (-128)
        av = 1'b0; bv = 1'b0; drain = 1'b1; cin = 20'h80010;
        step();
        drain = 1'b0; a = 8'h80; b = 8'h01; av = 1'b1; bv = 1'b1;
        step();
        check("sat_min", 32'(s_c), 32'h80000);
        check("sat_min_ovf", 32'(s_ovf), 32'h1);
        check("u_no_ovf_c", 32'(u_c), 32'h80090);

        // drain column: load 5/6/7, then shift out through the tail
        c_a0 = 8'd5; c_a1 = 8'd6; c_a2 = 8'd7; c_b = 8'd1;
        c_av = 1'b1; c_bv = 1'b1; c_af = 1'b1; av = 1'b0; bv = 1'b0;
        step();
        check("col_head", 32'(h_c), 32'd5);
        check("col_tail0", 32'(t_c), 32'd7);
        c_af = 1'b0; c_drain = 1'b1; c_head = '0;
        c_a0 = 8'd9; c_a1 = 8'd9; c_a2 = 8'd9;
        step();
        check("col_tail1", 32'(t_c), 32'd6);
        check("col_fwd_a", 32'(h_ao), 32'd9);
        check("col_fwd_vld", 32'(t_avo), 32'h1);
        step();
        check("col_tail2", 32'(t_c), 32'd5);
        step();
        check("col_tail3", 32'(t_c), 32'd0);
        check("col_mid3", 32'(m_c), 32'd0);
        check("col_head3", 32'(h_c), 32'd0);
        c_drain = 1'b0; c_av = 1'b0; c_bv = 1'b0;

        // lone A valid and lone first flag do not touch ACC
        a = 8'h03; av = 1'b1; bv = 1'b0; af = 1'b0;
        step();
        check("mismatch_c", 32'(s_c), 32'h80000);
        af = 1'b1;
        step();
        check("lone_first_c", 32'(s_c), 32'h80000);
        check("lone_first_fwd", 32'(s_afo), 32'h1);

        // reset beats drain and valid operands
        rst = 1'b1; drain = 1'b1; av = 1'b1; bv = 1'b1; cin = 20'd5;
        step();
        rst = 1'b0; drain = 1'b0; av = 1'b0; bv = 1'b0; af = 1'b0;
        check("rst2_c", 32'(s_c), 32'h0);
        check("rst2_ovf", 32'(s_ovf), 32'h0);
        check("rst2_aout", 32'(s_ao), 32'h0);
        check("rst2_avld", 32'(s_avo), 32'h0);
        check("rst2_afirst", 32'(s_afo), 32'h0);
        check("rst2_bvld", 32'(s_bvo), 32'h0);
        check("rst2_u_ovf", 32'(u_ovf), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
